perceptron_update_unit: RTL and testbench

//  Downstream consumer of the signed sample-field registers. Takes one bipolar training sample
//  (signed x1, x2, target) per valid/ready handshake and computes net = w1*x1 + w2*x2 + b.

---
 rtl/perceptron_update_unit_pkg.sv | 21 ++
 rtl/perceptron_update_unit_if.sv | 24 ++
 rtl/perceptron_update_unit_sat_add.sv | 30 +++
 rtl/perceptron_update_unit.sv | 141 ++++++++++++++
 tb/tb_perceptron_update_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/perceptron_update_unit_pkg.sv
// Shared types and constants for the perceptron update unit.
package perceptron_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  // Two-bit signed encoding of the perceptron decision
  localparam logic [1:0] Y_POS  = 2'b01;
  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_NEG  = 2'b11;

  // Bipolar value of a target bit: 1 -> +1, 0 -> -1
  function automatic logic signed [1:0] bip(input logic t);
    return t ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/perceptron_update_unit_if.sv
// Sample input handshake and per-sample result channel of the update unit.
interface perceptron_update_unit_if #(
  parameter int X_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [X_W-1:0] x1;
  logic signed [X_W-1:0] x2;
  logic                  target;
  logic                  epoch_last;
  logic                  out_valid;
  logic [1:0]            y_out;
  logic                  upd;

  modport master (
    output in_valid, x1, x2, target, epoch_last,
    input  in_ready, out_valid, y_out, upd
  );

  modport slave (
    input  in_valid, x1, x2, target, epoch_last,
    output in_ready, out_valid, y_out, upd
  );
endinterface

// File: rtl/perceptron_update_unit_sat_add.sv
// Signed saturating adder: W_W-bit accumulator plus B_W-bit addend, clamped to W_W bits.
module sat_add #(
  parameter int W_W = 10,
  parameter int B_W = 10
) (
  input  logic signed [W_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [W_W-1:0] sum_o,
  output logic                  ovf_o
);
  localparam int SW = ((W_W > B_W) ? W_W : B_W) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-W_W+1){1'b1}}, {(W_W-1){1'b0}}};

  logic signed [SW-1:0] full;

  // Full-precision sum, then clamp into the W_W-bit signed range
  always_comb begin
    full  = SW'(a_i) + SW'(b_i);
    ovf_o = 1'b0;
    sum_o = full[W_W-1:0];
    if (full > MAXV) begin
      sum_o = MAXV[W_W-1:0];
      ovf_o = 1'b1;
    end else if (full < MINV) begin
      sum_o = MINV[W_W-1:0];
      ovf_o = 1'b1;
    end
  end
endmodule

// File: rtl/perceptron_update_unit.sv
// Perceptron training unit: one bipolar sample per handshake, 4-cycle
// IDLE/MUL/CMP/UPD pipeline, saturating weight updates, epoch convergence flag.
module perceptron_update_unit
  import perceptron_pkg::*;
#(
  parameter int X_W   = 6,
  parameter int W_W   = 10,
  parameter int LR    = 1,
  parameter int THETA = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  perceptron_update_unit_if.slave bus,
  input  logic                  ld,
  input  logic signed [W_W-1:0] w1_init,
  input  logic signed [W_W-1:0] w2_init,
  input  logic signed [W_W-1:0] b_init,
  output logic signed [W_W-1:0] w1,
  output logic signed [W_W-1:0] w2,
  output logic signed [W_W-1:0] b,
  output logic                  sat,
  output logic [7:0]            epoch_errs,
  output logic                  converged
);
  localparam int P_W = W_W + X_W;
  localparam int N_W = W_W + X_W + 2;
  localparam int T_W = X_W + 16;
  localparam logic signed [N_W-1:0] TH_P = N_W'(THETA);
  localparam logic signed [N_W-1:0] TH_N = -TH_P;
  localparam logic signed [T_W-1:0] LR_T = T_W'(LR);

  state_t state_q, state_d;
  logic signed [X_W-1:0] x1_q, x2_q;
  logic                  t_q, last_q;
  logic signed [P_W-1:0] p1_q, p2_q;
  logic [1:0]            y_q;
  logic signed [W_W-1:0] w1_q, w2_q, b_q;
  logic                  sat_q, conv_q;
  logic [7:0]            errs_q;
  logic                  out_valid_q, upd_q;
  logic [1:0]            y_out_q;

  logic signed [N_W-1:0] net;
  logic signed [T_W-1:0] dx1, dx2, db;
  logic signed [W_W-1:0] w1_s, w2_s, b_s;
  logic                  o1, o2, o3;
  logic                  need_upd;
  logic [7:0]            errs_next;

  assign net      = N_W'(p1_q) + N_W'(p2_q) + N_W'(b_q);
  assign need_upd = (y_q != bip(t_q));
  assign dx1      = t_q ? T_W'(x1_q) * LR_T : -(T_W'(x1_q) * LR_T);
  assign dx2      = t_q ? T_W'(x2_q) * LR_T : -(T_W'(x2_q) * LR_T);
  assign db       = t_q ? LR_T : -LR_T;
  assign errs_next = need_upd ? ((errs_q == 8'hFF) ? errs_q : errs_q + 8'd1) : errs_q;

  sat_add #(.W_W(W_W), .B_W(T_W)) u_add_w1 (.a_i(w1_q), .b_i(dx1), .sum_o(w1_s), .ovf_o(o1));
  sat_add #(.W_W(W_W), .B_W(T_W)) u_add_w2 (.a_i(w2_q), .b_i(dx2), .sum_o(w2_s), .ovf_o(o2));
  sat_add #(.W_W(W_W), .B_W(T_W)) u_add_b  (.a_i(b_q),  .b_i(db),  .sum_o(b_s),  .ovf_o(o3));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake ready; ld blocks acceptance in IDLE
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = ~ld;
        if (!ld && bus.in_valid) state_d = S_MUL;
      end
      S_MUL:   state_d = S_CMP;
      S_CMP:   state_d = S_UPD;
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture, multiply, compare, update and epoch bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0; x2_q <= '0; t_q <= 1'b0; last_q <= 1'b0;
      p1_q <= '0; p2_q <= '0; y_q <= Y_ZERO;
      w1_q <= '0; w2_q <= '0; b_q <= '0;
      sat_q <= 1'b0; conv_q <= 1'b0; errs_q <= '0;
      out_valid_q <= 1'b0; upd_q <= 1'b0; y_out_q <= Y_ZERO;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld) begin
            w1_q <= w1_init; w2_q <= w2_init; b_q <= b_init;
            sat_q <= 1'b0; errs_q <= '0; conv_q <= 1'b0;
          end else if (bus.in_valid) begin
            x1_q <= bus.x1; x2_q <= bus.x2;
            t_q <= bus.target; last_q <= bus.epoch_last;
          end
        end
        S_MUL: begin
          p1_q <= P_W'(w1_q) * P_W'(x1_q);
          p2_q <= P_W'(w2_q) * P_W'(x2_q);
        end
        S_CMP: begin
          if (net > TH_P)      y_q <= Y_POS;
          else if (net < TH_N) y_q <= Y_NEG;
          else                 y_q <= Y_ZERO;
        end
        S_UPD: begin
          out_valid_q <= 1'b1;
          y_out_q     <= y_q;
          upd_q       <= need_upd;
          if (need_upd) begin
            w1_q  <= w1_s; w2_q <= w2_s; b_q <= b_s;
            sat_q <= sat_q | o1 | o2 | o3;
          end
          if (last_q) begin
            conv_q <= (errs_next == 8'd0);
            errs_q <= '0;
          end else begin
            errs_q <= errs_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_out_q;
  assign bus.upd       = upd_q;
  assign w1            = w1_q;
  assign w2            = w2_q;
  assign b             = b_q;
  assign sat           = sat_q;
  assign epoch_errs    = errs_q;
  assign converged     = conv_q;
endmodule

// File: tb/tb_perceptron_update_unit.sv
// Testbench for perceptron_update_unit: table of ld/sample steps with hand-derived
// expectations, results checked from a scoreboard queue when out_valid pulses.
module tb_perceptron_update_unit;
  logic clk = 1'b0;
  logic rst;
  logic ld;
  logic signed [9:0] w1_init, w2_init, b_init;
  logic signed [9:0] w1, w2, b;
  logic       sat, converged;
  logic [7:0] epoch_errs;

  always #5 clk = ~clk;

  perceptron_update_unit_if #(.X_W(6)) bus ();

  perceptron_update_unit #(.X_W(6), .W_W(10), .LR(1), .THETA(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ld(ld),
    .w1_init(w1_init), .w2_init(w2_init), .b_init(b_init),
    .w1(w1), .w2(w2), .b(b), .sat(sat),
    .epoch_errs(epoch_errs), .converged(converged)
  );

  typedef struct {
    int is_ld; int a; int bb; int c; int t; int last;
    int y; int upd; int w1; int w2; int b; int sat; int errs; int conv;
  } vec_t;

  typedef struct {
    int y; int upd; int w1; int w2; int b; int sat; int errs; int conv;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y_out", int'($signed(bus.y_out)), e.y);
        chk("upd", int'(bus.upd), e.upd);
        chk("w1", int'(w1), e.w1);
        chk("w2", int'(w2), e.w2);
        chk("b", int'(b), e.b);
        chk("sat", int'(sat), e.sat);
        chk("epoch_errs", int'(epoch_errs), e.errs);
        chk("converged", int'(converged), e.conv);
      end
    end
  end

  task automatic do_ld(input int iw1, input int iw2, input int ib, input int with_valid);
    @(negedge clk);
    ld = 1'b1;
    w1_init = 10'(iw1); w2_init = 10'(iw2); b_init = 10'(ib);
    bus.in_valid = (with_valid != 0);
    #1 chk("in_ready_during_ld", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 ld = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_sample(input int x1, input int x2, input int t, input int last, input exp_t e);
    int n;
    @(negedge clk);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.x1 = 6'(x1); bus.x2 = 6'(x2);
    bus.target = (t != 0); bus.epoch_last = (last != 0);
    bus.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin n = k; break; end
    end
    chk("latency_edges", n, 3);
    if (n == 0) void'(sb.pop_front());
    chk("in_ready_out_cycle", int'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    //           ld   a    b    c    t  last  y  upd  w1   w2   b   sat errs conv
    tbl[0]  = '{1,   0,   0,   0,   0, 0,   0, 0,   0,   0,   0,   0, 0, 0};
    tbl[1]  = '{0,   3,  -2,   0,   1, 0,   0, 1,   3,  -2,   1,   0, 1, 0};
    tbl[2]  = '{0,   3,  -2,   0,   1, 0,   1, 0,   3,  -2,   1,   0, 1, 0};
    tbl[3]  = '{1,   0,   0,   0,   0, 0,   0, 0,   0,   0,   0,   0, 0, 0};
    tbl[4]  = '{0,   3,  -2,   0,   1, 0,   0, 1,   3,  -2,   1,   0, 1, 0};
    tbl[5]  = '{0,  -3,   2,   0,   0, 1,  -1, 0,   3,  -2,   1,   0, 0, 0};
    tbl[6]  = '{0,   3,  -2,   0,   1, 0,   1, 0,   3,  -2,   1,   0, 0, 0};
    tbl[7]  = '{0,  -3,   2,   0,   0, 1,  -1, 0,   3,  -2,   1,   0, 0, 1};
    tbl[8]  = '{1, 511,-511,   0,   0, 0,   0, 0, 511,-511,   0,   0, 0, 0};
    tbl[9]  = '{0,   5,  31,   0,   1, 0,  -1, 1, 511,-480,   1,   1, 1, 0};
    tbl[10] = '{0,  -4,   1,   0,   1, 1,  -1, 1, 507,-479,   2,   1, 0, 0};
    tbl[11] = '{1, 100,   0,-512,   0, 0,   0, 0, 100,   0,-512,   0, 0, 0};
    tbl[12] = '{0,  10,   0,   0,   0, 0,   1, 1,  90,   0,-512,   1, 1, 0};

    rst = 1'b1; ld = 1'b0;
    w1_init = '0; w2_init = '0; b_init = '0;
    bus.in_valid = 1'b0; bus.x1 = '0; bus.x2 = '0;
    bus.target = 1'b0; bus.epoch_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_w1", int'(w1), 0);
    chk("rst_w2", int'(w2), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_converged", int'(converged), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_epoch_errs", int'(epoch_errs), 0);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].is_ld != 0) begin
        do_ld(tbl[i].a, tbl[i].bb, tbl[i].c, 0);
        @(negedge clk);
        chk("ld_w1", int'(w1), tbl[i].w1);
        chk("ld_w2", int'(w2), tbl[i].w2);
        chk("ld_b", int'(b), tbl[i].b);
        chk("ld_sat", int'(sat), tbl[i].sat);
        chk("ld_errs", int'(epoch_errs), tbl[i].errs);
        chk("ld_conv", int'(converged), tbl[i].conv);
      end else begin
        e = '{tbl[i].y, tbl[i].upd, tbl[i].w1, tbl[i].w2, tbl[i].b,
              tbl[i].sat, tbl[i].errs, tbl[i].conv};
        do_sample(tbl[i].a, tbl[i].bb, tbl[i].t, tbl[i].last, e);
      end
    end

    // Reset while a sample sits in CMP: sample is dropped, weights cleared
    @(negedge clk);
    bus.x1 = 6'(3); bus.x2 = -6'sd2; bus.target = 1'b1; bus.epoch_last = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_w1", int'(w1), 0);
    chk("abort_w2", int'(w2), 0);
    chk("abort_b", int'(b), 0);
    chk("abort_sat", int'(sat), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_out_valid", int'(bus.out_valid), 0);
    end

    // ld and in_valid together: load wins, no sample accepted
    bus.x1 = 6'(1); bus.x2 = 6'(1); bus.target = 1'b1;
    do_ld(7, -3, 2, 1);
    chk("ldwin_w1", int'(w1), 7);
    chk("ldwin_w2", int'(w2), -3);
    chk("ldwin_b", int'(b), 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ldwin_no_out_valid", int'(bus.out_valid), 0);
    end

    // Unit still trains normally afterwards: net = 7 - 3 + 2 = 6 -> +1, no update
    e = '{1, 0, 7, -3, 2, 0, 0, 0};
    do_sample(1, 1, 1, 0, e);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
